// File: rtl/riscv_bus_pkg.sv
// Shared encodings and defaults for the fetch/data memory bus arbiter.
// Imported by the arbiter top and its timeout timer.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUS_I = 2'd1,
    ARB_BUS_D = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/bus_timeout_timer.sv
// Cycle counter for an outstanding bus access.
// expired is high during the TIMEOUT-th enabled cycle.
module bus_timeout_timer
  import riscv_bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign expired = en && (cnt == LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and data ports.
// Data has priority; fetch wins after STARVE_MAX data grants.
module mem_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                grant_d,
  output logic                bus_err
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_t        state, state_n;
  logic [SW-1:0]     starve_cnt, starve_n;
  logic              bus_req_n, bus_we_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [DATA_W-1:0] bus_wdata_n;
  logic [BE_W-1:0]   bus_be_n;
  logic              grant_d_n, bus_err_n;
  logic [DATA_W-1:0] if_rdata_n, dm_rdata_n;
  logic              if_ack_n, dm_ack_n;

  logic take_d, take_i, owner, tmo_exp, done;

  assign take_d = dm_req && (!if_req || starve_cnt != SMAX);
  assign take_i = if_req && !take_d;
  assign owner  = (state == ARB_BUS_D) ? OWN_D : OWN_I;
  assign done   = bus_ack || tmo_exp;

  bus_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (state == ARB_IDLE),
    .en     (state != ARB_IDLE),
    .expired(tmo_exp)
  );

  always_comb begin
    state_n     = state;
    starve_n    = starve_cnt;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    bus_be_n    = bus_be;
    grant_d_n   = grant_d;
    bus_err_n   = bus_err;
    if_rdata_n  = if_rdata;
    dm_rdata_n  = dm_rdata;
    if_ack_n    = 1'b0;
    dm_ack_n    = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        unique case (1'b1)
          take_d: begin
            state_n     = ARB_BUS_D;
            bus_req_n   = 1'b1;
            bus_we_n    = dm_we;
            bus_addr_n  = dm_addr;
            bus_wdata_n = dm_wdata;
            bus_be_n    = dm_be;
            grant_d_n   = 1'b1;
            if (!if_req) starve_n = '0;
            else if (starve_cnt != SMAX) starve_n = starve_cnt + 1'b1;
          end
          take_i: begin
            state_n     = ARB_BUS_I;
            bus_req_n   = 1'b1;
            bus_we_n    = 1'b0;
            bus_addr_n  = if_addr;
            bus_wdata_n = '0;
            bus_be_n    = '1;
            grant_d_n   = 1'b0;
            starve_n    = '0;
          end
          default: ;
        endcase
      end
      ARB_BUS_I, ARB_BUS_D: begin
        // bus_ack beats a same-cycle timeout
        if (done) begin
          state_n   = ARB_IDLE;
          bus_req_n = 1'b0;
          grant_d_n = 1'b0;
          if (!bus_ack) bus_err_n = 1'b1;
          if (owner == OWN_D) begin
            dm_ack_n = 1'b1;
            if (!bus_ack) dm_rdata_n = '0;
            else if (!bus_we) dm_rdata_n = bus_rdata;
          end else begin
            if_ack_n   = 1'b1;
            if_rdata_n = bus_ack ? bus_rdata : '0;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= '0;
      grant_d    <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      bus_req    <= bus_req_n;
      bus_we     <= bus_we_n;
      bus_addr   <= bus_addr_n;
      bus_wdata  <= bus_wdata_n;
      bus_be     <= bus_be_n;
      grant_d    <= grant_d_n;
      bus_err    <= bus_err_n;
      if_rdata   <= if_rdata_n;
      dm_rdata   <= dm_rdata_n;
      if_ack     <= if_ack_n;
      dm_ack     <= dm_ack_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: RAM/ROM bus slave model,
// expected responses queued at issue, popped on each ack.
module tb_mem_bus_arbiter;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        grant_d;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  int fixed_delay = 0;

  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  bit          grant_log[$];
  logic [31:0] ref_mem[16];
  logic [31:0] slave_mem[16];
  logic [31:0] ref_last = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .grant_d(grant_d), .bus_err(bus_err)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] rom(logic [31:0] a);
    return {a[17:2], 16'h0033};
  endfunction

  function automatic logic [31:0] f_addr(int i);
    return 32'h1000_0000 + 32'(i << 2);
  endfunction

  function automatic logic [31:0] d_addr(int i);
    return 32'h2000_0000 + 32'(i << 2);
  endfunction

  task automatic if_access(input logic [31:0] a, output int lat);
    if_addr = a;
    if_req  = 1'b1;
    if_q.push_back(rom(a));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if_ack && lat < 600);
    chk("if_ack_wait", {31'd0, if_ack}, 1);
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input bit abort, output int lat);
    logic [31:0] want;
    if (abort) begin
      want = '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
      want = ref_last;
    end else begin
      want = ref_mem[a[5:2]];
    end
    ref_last = want;
    dm_q.push_back(want);
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
    dm_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dm_ack && lat < 600);
    chk("dm_ack_wait", {31'd0, dm_ack}, 1);
    dm_req = 1'b0;
  endtask

  // Bus slave: RAM for data region, ROM for fetch region
  initial begin
    int k, dly;
    k = 0;
    dly = 0;
    for (int i = 0; i < 16; i++) slave_mem[i] = 32'hC0DE_0000 + 32'(i);
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        k++;
        if (k == 1) begin
          dly = (fixed_delay < 0) ? int'($urandom_range(3)) : fixed_delay;
          grant_log.push_back(grant_d);
          if (grant_d) begin
            chk("bus_addr_d", bus_addr, dm_addr);
            chk("bus_we_d", {31'd0, bus_we}, {31'd0, dm_we});
            chk("bus_be_d", {28'd0, bus_be}, {28'd0, dm_be});
            if (dm_we) chk("bus_wdata_d", bus_wdata, dm_wdata);
          end else begin
            chk("bus_addr_i", bus_addr, if_addr);
            chk("bus_we_i", {31'd0, bus_we}, 0);
          end
        end
        if (k == dly + 1) begin
          bus_ack = 1'b1;
          if (bus_we) begin
            for (int b = 0; b < 4; b++)
              if (bus_be[b])
                slave_mem[bus_addr[5:2]][8*b +: 8] = bus_wdata[8*b +: 8];
          end else if (bus_addr[31:28] == 4'h1) begin
            bus_rdata = rom(bus_addr);
          end else begin
            bus_rdata = slave_mem[bus_addr[5:2]];
          end
        end
      end else begin
        k = 0;
      end
    end
  end

  // Monitor: pop and compare on every ack
  initial begin
    logic [31:0] want;
    forever begin
      @(negedge clk);
      if (if_ack) begin
        if (if_q.size() == 0) chk("if_ack_unexpected", {31'd0, if_ack}, 0);
        else begin
          want = if_q.pop_front();
          chk("if_rdata", if_rdata, want);
        end
      end
      if (dm_ack) begin
        if (dm_q.size() == 0) chk("dm_ack_unexpected", {31'd0, dm_ack}, 0);
        else begin
          want = dm_q.pop_front();
          chk("dm_rdata", dm_rdata, want);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_i, lat_d, gb, wait_c;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i);
    repeat (2) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 0);
    chk("rst_if_ack", {31'd0, if_ack}, 0);
    chk("rst_dm_ack", {31'd0, dm_ack}, 0);
    chk("rst_grant_d", {31'd0, grant_d}, 0);
    chk("rst_bus_err", {31'd0, bus_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // lone fetch, bus_ack two cycles after bus_req
    fixed_delay = 2;
    gb = grant_log.size();
    if_access(32'h1000_0000, lat);
    chk("lone_lat", lat, 4);
    chk("lone_grants", grant_log.size() - gb, 1);
    if (grant_log.size() > gb) chk("lone_grant_d", {31'd0, grant_log[gb]}, 0);

    // minimum latency load
    fixed_delay = 0;
    dm_access(1'b0, d_addr(1), '0, 4'hF, 1'b0, lat);
    chk("min_lat", lat, 2);

    // simultaneous requests: store goes first
    gb = grant_log.size();
    fork
      if_access(f_addr(2), lat_i);
      dm_access(1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011, 1'b0, lat_d);
    join
    chk("simul_grants", grant_log.size() - gb, 2);
    if (grant_log.size() > gb + 1) begin
      chk("simul_first_d", {31'd0, grant_log[gb]}, 1);
      chk("simul_second_i", {31'd0, grant_log[gb+1]}, 0);
    end
    chk("simul_if_lat", lat_i, 4);
    dm_access(1'b0, 32'h2000_0004, '0, 4'hF, 1'b0, lat);

    // continuous contention: 4 data grants then 1 fetch
    gb = grant_log.size();
    fork
      begin
        int l;
        repeat (3) if_access(f_addr($urandom_range(15)), l);
      end
      begin
        int l;
        repeat (12) dm_access(1'b0, d_addr($urandom_range(15)), '0, 4'hF, 1'b0, l);
      end
    join
    chk("starve_grants", grant_log.size() - gb, 15);
    for (int g = 0; g < 15 && gb + g < grant_log.size(); g++)
      chk("starve_seq", {31'd0, grant_log[gb+g]}, (g % 5 == 4) ? 0 : 1);

    // randomized traffic with random bus delays
    fixed_delay = -1;
    fork
      begin
        int l;
        repeat (20) begin
          repeat ($urandom_range(2)) @(negedge clk);
          if_access(f_addr($urandom_range(15)), l);
        end
      end
      begin
        int l;
        repeat (30) begin
          repeat ($urandom_range(2)) @(negedge clk);
          dm_access(1'($urandom_range(1)), d_addr($urandom_range(15)),
                    $urandom, 4'($urandom), 1'b0, l);
        end
      end
    join
    chk("rand_bus_err", {31'd0, bus_err}, 0);

    // bus_ack in the timeout cycle completes normally
    @(negedge clk);
    fixed_delay = TMO - 1;
    dm_access(1'b0, d_addr(7), '0, 4'hF, 1'b0, lat);
    chk("tmo_edge_lat", lat, TMO + 1);
    chk("tmo_edge_err", {31'd0, bus_err}, 0);

    // hung bus: abort with zero data and sticky error
    @(negedge clk);
    fixed_delay = 1000;
    dm_access(1'b0, d_addr(3), '0, 4'hF, 1'b1, lat);
    chk("tmo_lat", lat, TMO + 1);
    chk("tmo_err", {31'd0, bus_err}, 1);
    fixed_delay = 1;
    @(negedge clk);
    if_access(f_addr(9), lat);
    chk("post_tmo_lat", lat, 3);
    dm_access(1'b0, d_addr(3), '0, 4'hF, 1'b0, lat);
    chk("tmo_err_sticky", {31'd0, bus_err}, 1);

    // reset while data access is outstanding
    @(negedge clk);
    fixed_delay = 1000;
    dm_we = 1'b0; dm_addr = d_addr(5); dm_be = 4'hF;
    dm_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_grant_d", {31'd0, grant_d}, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_bus_req", {31'd0, bus_req}, 0);
    chk("mid_rst_dm_ack", {31'd0, dm_ack}, 0);
    chk("mid_rst_if_ack", {31'd0, if_ack}, 0);
    chk("mid_rst_grant_d", {31'd0, grant_d}, 0);
    chk("mid_rst_bus_err", {31'd0, bus_err}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    fixed_delay = 0;
    ref_last = '0;
    dm_q.push_back(ref_mem[5]);
    @(negedge clk);
    chk("regrant_bus_req", {31'd0, bus_req}, 1);
    chk("regrant_grant_d", {31'd0, grant_d}, 1);
    wait_c = 0;
    while (!dm_ack && wait_c < 10) begin
      @(negedge clk);
      wait_c++;
    end
    chk("regrant_dm_ack", {31'd0, dm_ack}, 1);
    dm_req = 1'b0;

    repeat (4) @(negedge clk);
    chk("if_q_empty", if_q.size(), 0);
    chk("dm_q_empty", dm_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
